// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per clock,
// quotient to LO and remainder to HI, with a one-cycle done pulse for the HiLo write.
module hilo_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  if (2**CNT_W != WIDTH) begin : g_bad_cnt_w
    $error("hilo_divider: CNT_W must satisfy 2**CNT_W == WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    a_mag = dataA;
    b_mag = dataB;
    if (sign_mode && dataA[WIDTH-1]) a_mag = ~dataA + ONE;
    if (sign_mode && dataB[WIDTH-1]) b_mag = ~dataB + ONE;
  end

  // The shifted remainder keeps its carry-out bit so full-range unsigned divisors work.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor};
    rem_step = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  // In the divide-by-zero case rem holds the raw dividend captured at start.
  always_comb begin
    q_fix = q_neg ? (~quo + ONE) : quo;
    r_fix = r_neg ? (~rem + ONE) : rem;
    if (dz) begin
      q_fix = '1;
      r_fix = rem;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!flush && start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (dataB == '0) begin
              dz    <= 1'b1;
              rem   <= dataA;
              quo   <= '0;
              state <= FIX;
            end else begin
              dz      <= 1'b0;
              rem     <= '0;
              quo     <= a_mag;
              divisor <= b_mag;
              q_neg   <= (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & sign_mode;
              r_neg   <= dataA[WIDTH-1] & sign_mode;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= dz;
            done        <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Multi-cycle iterative divider for the EX stage; the inverse counterpart of the multiplier path.
- Takes the dividend/divisor from the register operands on a start pulse.
- Runs one restoring-division step per clock.
- Presents the quotient (LO) and remainder (HI) with a one-cycle done pulse, which the HiLo register uses as its write enable.
- Supports signed DIV (funct 6'b011010) and unsigned DIVU (funct 6'b011011); funct decode stays in the ALU controller.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request; sampled only in IDLE
- sign_mode  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start
- flush  input  1  synchronous abort from pipeline squash
- dataA  input  WIDTH  dividend; sampled with start
- dataB  input  WIDTH  divisor; sampled with start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  registered flag for the last completed op
- quotient  output  WIDTH  to LO
- remainder  output  WIDTH  to HI

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; counter and work registers cleared. This applies mid-operation too; no done is emitted.
- States and transitions:
  - IDLE: start=1 with dataB!=0 -> CALC. Latch |A| and |B| (magnitudes when sign_mode=1, raw values otherwise), q_neg=A[31]^B[31]&sign_mode, r_neg=A[31]&sign_mode, counter=0.
  - IDLE: start=1 with dataB==0 -> FIX with dz=1.
  - CALC: each edge performs one restoring step: shift {rem,quo} left 1; trial = rem_shifted - divisor (WIDTH+1 bits); if non-negative, rem=trial and quo LSB=1. counter++. The edge with counter==WIDTH-1 -> FIX.
  - FIX: one edge, then -> IDLE. Writes the outputs and sets done=1 for the following cycle only.
    - Normal op: quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem; div_by_zero=0.
    - dz=1: quotient=32'hFFFFFFFF, remainder=dataA as latched, div_by_zero=1.
- Latency: start sampled at edge E0.
  - Normal op: done high in the cycle after edge E33 (WIDTH+2 edges).
  - Divide by zero: done high after edge E1.
- busy is high from the cycle after E0 until done is asserted. busy=0 in the done cycle, so a new start may be accepted in the done cycle.
- start while busy=1: ignored; no queueing.
- flush=1 in CALC/FIX: -> IDLE at next edge; done not pulsed; quotient/remainder/div_by_zero keep their previous values.
- flush=1 in IDLE has priority over start (the request is dropped).
- Outputs hold their values between done pulses.
- Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0, done normally; no trap.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- All arithmetic is modulo 2**WIDTH. Two's-complement negation is ~x+1.

Test Plan:
- Unsigned 100/7: reset, start with sign_mode=0, dataA=100, dataB=7 -> busy high 33 cycles; done after edge E33; quotient=14, remainder=2, div_by_zero=0.
- Signed -100/7: dataA=32'hFFFFFF9C, dataB=7, sign_mode=1 -> quotient=32'hFFFFFFF2, remainder=32'hFFFFFFFE. Also 100/-7 -> quotient=32'hFFFFFFF2, remainder=2.
- Divide by zero: dataA=32'h1234, dataB=0 -> done after E1; quotient=32'hFFFFFFFF, remainder=32'h1234, div_by_zero=1. A following 9/3 op clears div_by_zero to 0.
- Boundaries:
  - Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
- Start during busy and flush:
  - Start 100/7, then pulse start with 50/5 at cycle 10 -> ignored; result stays 14/2.
  - Start 200/3, flush at cycle 15 -> no done; outputs stay 14/2; a new start is accepted the next cycle.
- Reset mid-op: drive reset=0 asynchronously at cycle 20 of a divide -> outputs go to 0 immediately without waiting for a clock edge; no done after release; the next 9/3 op yields quotient=3, remainder=0.
